// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and MIPS field positions.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W    = 32;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RT_W       = 5;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned INDEX_LSB  = 0;
    localparam int unsigned INDEX_W    = 26;

    // Word address alignment: low two bits of every fetch address must be zero
    localparam int unsigned ALIGN_W    = 2;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Extract the opcode field of an instruction word
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPCODE_LSB +: OPCODE_W];
    endfunction

    // Extract the rt register field of an instruction word
    function automatic logic [RT_W-1:0] get_rt(input logic [INSTR_W-1:0] word);
        return word[RT_LSB +: RT_W];
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection for retire: jr > jump > taken branch > sequential, modulo 2^ADDR_W.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               jr,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               misaligned
);

    logic [IMM_W-1:0]   imm;
    logic [INDEX_W-1:0] index;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  br_offset;
    logic [ADDR_W-1:0]  br_pc;
    logic [ADDR_W-1:0]  j_pc;
    logic               unused_opcode;

    assign imm   = instr[IMM_LSB +: IMM_W];
    assign index = instr[INDEX_LSB +: INDEX_W];

    // Opcode bits are decoded elsewhere; only the offset/index fields matter here
    assign unused_opcode = ^instr[OPCODE_LSB +: OPCODE_W];

    assign seq_pc = pc + ADDR_W'(4);

    // Branch offset is the sign-extended immediate scaled to a byte offset
    assign br_offset = {{(ADDR_W - IMM_W - ALIGN_W){imm[IMM_W-1]}}, imm, {ALIGN_W{1'b0}}};
    assign br_pc     = seq_pc + br_offset;

    // Jump target keeps the upper region bits of the delay-slot address
    assign j_pc = {seq_pc[ADDR_W-1:INDEX_W+ALIGN_W], index, {ALIGN_W{1'b0}}};

    // Prioritised target select
    always_comb begin
        next_pc = seq_pc;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = j_pc;
        end else if (branch_taken) begin
            next_pc = br_pc;
        end
    end

    // Only a register target can be unaligned; the check covers every path anyway
    assign misaligned = (next_pc[ALIGN_W-1:0] != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ready handshake, instruction register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,

    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,

    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [RT_W-1:0]     rt_field,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,

    input  logic                retire,
    input  logic                branch_taken,
    input  logic                jump,
    input  logic                jr,
    input  logic [ADDR_W-1:0]   jr_target,

    output logic                fault
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] next_pc;
    logic              next_misaligned;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc           (pc),
        .instr        (instr),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    // Decoder-facing views derived straight from the architectural registers
    assign opcode    = get_opcode(instr);
    assign rt_field  = get_rt(instr);
    assign pc_plus4  = pc + ADDR_W'(4);
    assign imem_addr = pc;

    // Fetch sequencer: issue request, capture word, wait for retire, advance or halt
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            // Keep the faulting instruction's PC visible for debug
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end

                ST_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, next-PC paths, wrap, fault and reset behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic        fault;

    int checks;
    int failures;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .rt_field     (rt_field),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .retire       (retire),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for a request, then answer it with one word in the same cycle
    task automatic serve_fetch(input logic [31:0] word, output logic [31:0] addr, output bit ok);
        ok   = 1'b0;
        addr = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            addr       = imem_addr;
            imem_rdata = word;
            imem_ready = 1'b1;
            @(posedge clk); #1;
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    // Pulse retire for one cycle with the given control-flow inputs
    task automatic do_retire(input bit br, input bit j, input bit r, input logic [31:0] tgt);
        retire       = 1'b1;
        branch_taken = br;
        jump         = j;
        jr           = r;
        jr_target    = tgt;
        @(posedge clk); #1;
        retire       = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl req=%b valid=%b fault=%b exp 0/0/0", imem_req, instr_valid, fault);
        end
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs pc=%h instr=%h exp 0/0", pc, instr);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit          ok;
        serve_fetch(32'h2002_0005, a, ok);
        checks++;
        if (!ok || a !== 32'h0) begin
            failures++;
            $display("FAIL seq_first_addr ok=%0d addr=%h exp 00000000", ok, a);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2002_0005 || opcode !== 6'h08 || rt_field !== 5'd2) begin
            failures++;
            $display("FAIL seq_capture valid=%b instr=%h op=%h rt=%0d exp 1/20020005/08/2",
                     instr_valid, instr, opcode, rt_field);
        end
        do_retire(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_next req=%b addr=%h valid=%b exp 1/00000004/0", imem_req, imem_addr, instr_valid);
        end
        serve_fetch(32'h0000_0000, a, ok);
        checks++;
        if (!ok || a !== 32'h4) begin
            failures++;
            $display("FAIL seq_second_addr ok=%0d addr=%h exp 00000004", ok, a);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        bit          ok;
        do_retire(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        serve_fetch(32'h1022_FFFE, a, ok);
        checks++;
        if (!ok || a !== 32'h100 || opcode !== 6'h04 || rt_field !== 5'd2) begin
            failures++;
            $display("FAIL br_fetch ok=%0d addr=%h op=%h rt=%0d exp 00000100/04/2", ok, a, opcode, rt_field);
        end
        do_retire(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_00FC || pc !== 32'h0000_00FC) begin
            failures++;
            $display("FAIL br_target req=%b addr=%h pc=%h exp 1/000000fc", imem_req, imem_addr, pc);
        end
        serve_fetch(32'h0000_0000, a, ok);
    endtask

    task automatic test_jump();
        logic [31:0] a;
        bit          ok;
        do_retire(1'b0, 1'b0, 1'b1, 32'h0040_0010);
        serve_fetch(32'h0C00_0100, a, ok);
        checks++;
        if (!ok || a !== 32'h0040_0010 || pc_plus4 !== 32'h0040_0014) begin
            failures++;
            $display("FAIL jmp_fetch ok=%0d addr=%h pc_plus4=%h exp 00400010/00400014", ok, a, pc_plus4);
        end
        do_retire(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0400) begin
            failures++;
            $display("FAIL jmp_target req=%b addr=%h exp 1/00000400", imem_req, imem_addr);
        end
        serve_fetch(32'h0000_0000, a, ok);
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit          ok;
        do_retire(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        serve_fetch(32'h0000_0000, a, ok);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_fetch ok=%0d addr=%h pc_plus4=%h exp fffffffc/00000000", ok, a, pc_plus4);
        end
        do_retire(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_delayed_ready();
        logic [31:0] a;
        bit          ok;
        // Retire while fetching must be ignored
        retire = 1'b1;
        jr        = 1'b1;
        jr_target = 32'h0000_0800;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL delay_hold cyc=%0d req=%b addr=%h valid=%b exp 1/00000000/0",
                         i, imem_req, imem_addr, instr_valid);
            end
        end
        retire    = 1'b0;
        jr        = 1'b0;
        jr_target = 32'h0;
        serve_fetch(32'h8C43_0004, a, ok);
        checks++;
        if (!ok || a !== 32'h0 || instr_valid !== 1'b1 || instr !== 32'h8C43_0004) begin
            failures++;
            $display("FAIL delay_capture ok=%0d addr=%h valid=%b instr=%h exp 00000000/1/8c430004",
                     ok, a, instr_valid, instr);
        end
        do_retire(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_fetch();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL mid_pre req=%b addr=%h exp 1/00000004", imem_req, imem_addr);
        end
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset req=%b pc=%h valid=%b exp 0/00000000/0", imem_req, pc, instr_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_late_ready valid=%b instr=%h pc=%h req=%b exp 0/00000000/00000000/1",
                     instr_valid, instr, pc, imem_req);
        end
    endtask

    task automatic test_jr_fault();
        logic [31:0] a;
        bit          ok;
        serve_fetch(32'h03E0_0008, a, ok);
        checks++;
        if (!ok || a !== 32'h0) begin
            failures++;
            $display("FAIL fault_fetch ok=%0d addr=%h exp 00000000", ok, a);
        end
        do_retire(1'b0, 1'b0, 1'b1, 32'h0000_0202);
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_enter fault=%b req=%b pc=%h valid=%b exp 1/0/00000000/0",
                     fault, imem_req, pc, instr_valid);
        end
        retire     = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL fault_halt cyc=%0d fault=%b req=%b pc=%h valid=%b exp 1/0/00000000/0",
                         i, fault, imem_req, pc, instr_valid);
            end
        end
        retire     = 1'b0;
        imem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (fault !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL fault_clear fault=%b pc=%h exp 0/00000000", fault, pc);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = 32'hDEAD_BEEF;
        retire       = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'h0;

        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_delayed_ready();
        test_reset_mid_fetch();
        test_jr_fault();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
